expr_stream_gen: RTL and testbench

// - Serialiser that emits a well-formed ASCII expression, one char per handshake, for the expression checker.
// - Grammar: digit ( op digit )*, where digit='0'..'9' (8'd48..8'd57) and op='+' (8'd43) or '*' (8'd42).
// - Loaded from a parallel term/operator vector.
// - Sits upstream of the checker. Any accepted job yields a stream that the checker ends with out=1.

---
 rtl/expr_pkg.sv | 13 +
 rtl/expr_job_regs.sv | 41 ++++
 rtl/expr_stream_gen.sv | 121 ++++++++++++
 tb/tb_expr_stream_gen.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/expr_pkg.sv
// Shared constants and state encoding for the expression stream generator and checker.
package expr_pkg;
  localparam logic [7:0] CH_ZERO = 8'd48;
  localparam logic [7:0] CH_NINE = 8'd57;
  localparam logic [7:0] CH_PLUS = 8'd43;
  localparam logic [7:0] CH_MUL  = 8'd42;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIGIT = 2'd1,
    ST_OP    = 2'd2
  } state_t;
endpackage

// File: rtl/expr_job_regs.sv
// Job holding registers: latches len/terms/ops on load and muxes out the selected term and operator.
module expr_job_regs #(
  parameter int unsigned MAX_TERMS = 8,
  localparam int unsigned LEN_W = $clog2(MAX_TERMS + 1)
) (
  input  logic                   clk,
  input  logic                   i_load,
  input  logic [LEN_W-1:0]       i_len,
  input  logic [4*MAX_TERMS-1:0] i_terms,
  input  logic [MAX_TERMS-2:0]   i_ops,
  input  logic [LEN_W-1:0]       i_term_idx,
  input  logic [LEN_W-1:0]       i_op_idx,
  output logic [LEN_W-1:0]       o_len,
  output logic [3:0]             o_term,
  output logic                   o_op
);
  logic [LEN_W-1:0]       r_len;
  logic [4*MAX_TERMS-1:0] r_terms;
  logic [MAX_TERMS-2:0]   r_ops;

  always_ff @(posedge clk) begin
    if (i_load) begin
      r_len   <= i_len;
      r_terms <= i_terms;
      r_ops   <= i_ops;
    end
  end

  assign o_len = r_len;

  always_comb begin
    o_term = '0;
    o_op   = 1'b0;
    for (int unsigned i = 0; i < MAX_TERMS; i++) begin
      if (i_term_idx == LEN_W'(i)) o_term = r_terms[4*i +: 4];
    end
    for (int unsigned i = 0; i < MAX_TERMS - 1; i++) begin
      if (i_op_idx == LEN_W'(i)) o_op = r_ops[i];
    end
  end
endmodule

// File: rtl/expr_stream_gen.sv
// Serialises a parallel term/operator job into an ASCII "digit (op digit)*" stream
// over a valid/ready handshake.
module expr_stream_gen
  import expr_pkg::*;
#(
  parameter int unsigned MAX_TERMS = 8,
  localparam int unsigned LEN_W = $clog2(MAX_TERMS + 1)
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic [LEN_W-1:0]       len,
  input  logic [4*MAX_TERMS-1:0] terms,
  input  logic [MAX_TERMS-2:0]   ops,
  output logic [7:0]             ch,
  output logic                   ch_valid,
  input  logic                   ch_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  state_t           r_state, w_state_n;
  logic [7:0]       r_ch, w_ch_n;
  logic [LEN_W-1:0] r_idx, w_idx_n;
  logic             r_done, w_done_n;
  logic             r_err, w_err_n;
  logic             w_load, w_legal;
  logic [LEN_W-1:0] w_len_q;
  logic [3:0]       w_term;
  logic             w_op;

  expr_job_regs #(.MAX_TERMS(MAX_TERMS)) u_job_regs (
    .clk        (clk),
    .i_load     (w_load),
    .i_len      (len),
    .i_terms    (terms),
    .i_ops      (ops),
    .i_term_idx (r_idx + LEN_W'(1)),
    .i_op_idx   (r_idx),
    .o_len      (w_len_q),
    .o_term     (w_term),
    .o_op       (w_op)
  );

  // Only terms below len matter; anything above is don't-care.
  always_comb begin
    w_legal = (len != '0) && (len <= LEN_W'(MAX_TERMS));
    for (int unsigned i = 0; i < MAX_TERMS; i++) begin
      if ((LEN_W'(i) < len) && (terms[4*i +: 4] > 4'd9)) w_legal = 1'b0;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_ch_n    = r_ch;
    w_idx_n   = r_idx;
    w_done_n  = 1'b0;
    w_err_n   = 1'b0;
    w_load    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_legal) begin
            // First digit comes straight from the port; the latched copy is not valid yet.
            w_load    = 1'b1;
            w_idx_n   = '0;
            w_state_n = ST_DIGIT;
            w_ch_n    = CH_ZERO + {4'b0, terms[3:0]};
          end else begin
            w_err_n = 1'b1;
          end
        end
      end
      ST_DIGIT: begin
        if (ch_ready) begin
          if (r_idx == w_len_q - LEN_W'(1)) begin
            w_state_n = ST_IDLE;
            w_ch_n    = '0;
            w_done_n  = 1'b1;
          end else begin
            w_state_n = ST_OP;
            w_ch_n    = w_op ? CH_MUL : CH_PLUS;
          end
        end
      end
      ST_OP: begin
        if (ch_ready) begin
          w_idx_n   = r_idx + LEN_W'(1);
          w_state_n = ST_DIGIT;
          w_ch_n    = CH_ZERO + {4'b0, w_term};
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_ch_n    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_IDLE;
      r_ch    <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_ch    <= w_ch_n;
      r_idx   <= w_idx_n;
      r_done  <= w_done_n;
      r_err   <= w_err_n;
    end
  end

  assign ch       = r_ch;
  assign ch_valid = (r_state != ST_IDLE);
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign err      = r_err;
endmodule

// File: tb/tb_expr_stream_gen.sv
// Directed and random jobs against a queue-based stream model plus a grammar/checker model.
module tb_expr_stream_gen;
  import expr_pkg::*;

  localparam int unsigned MAX_TERMS = 8;
  localparam int unsigned LEN_W = $clog2(MAX_TERMS + 1);

  logic                   clk = 1'b0;
  logic                   clr, start, ch_ready;
  logic [LEN_W-1:0]       len;
  logic [4*MAX_TERMS-1:0] terms;
  logic [MAX_TERMS-2:0]   ops;
  logic [7:0]             ch;
  logic                   ch_valid, busy, done, err;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  expr_stream_gen #(.MAX_TERMS(MAX_TERMS)) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .len      (len),
    .terms    (terms),
    .ops      (ops),
    .ch       (ch),
    .ch_valid (ch_valid),
    .ch_ready (ch_ready),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected stream: digit, then op/digit pairs, straight from the job description.
  function automatic void build(input int n, input logic [31:0] t, input logic [6:0] o);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(8'(48 + ((t >> (4 * i)) & 32'hF)));
      if (i < n - 1) exp_q.push_back(o[i] ? 8'd42 : 8'd43);
    end
  endfunction

  // Called right after a negedge; returns at the negedge of the done cycle.
  // mode 0: ready always high, 1: random ready, 2: stall 3 cycles on first '*'.
  task automatic run_job(input int n, input logic [31:0] t, input logic [6:0] o, input int mode);
    int k, cyc, stalls;
    bit r, expect_digit, model_out, ok;
    build(n, t, o);
    start = 1'b1; len = LEN_W'(n); terms = t; ops = o;
    @(negedge clk);
    start = 1'b0;
    len = LEN_W'($urandom); terms = $urandom; ops = 7'($urandom);
    k = 0; cyc = 0; stalls = 0; expect_digit = 1'b1; model_out = 1'b0;
    while (k < exp_q.size() && cyc < 400) begin
      chk("ch_valid", ch_valid, 1);
      chk("ch", ch, exp_q[k]);
      chk("busy", busy, 1);
      chk("done_low", done, 0);
      chk("err_low", err, 0);
      case (mode)
        0: r = 1'b1;
        1: r = ($urandom_range(0, 3) != 0);
        default: begin
          if (ch == CH_MUL && stalls < 3) begin r = 1'b0; stalls++; end
          else r = 1'b1;
        end
      endcase
      ch_ready = r;
      if (r) begin
        ok = expect_digit ? (ch >= CH_ZERO && ch <= CH_NINE) : (ch == CH_PLUS || ch == CH_MUL);
        chk("grammar", ok, 1);
        model_out = expect_digit;
        expect_digit = !expect_digit;
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("stream_complete", k, exp_q.size());
    chk("checker_out", model_out, 1);
    if (mode == 2) chk("stall_cycles", stalls, 3);
    chk("done", done, 1);
    chk("valid_off", ch_valid, 0);
    chk("busy_off", busy, 0);
    chk("ch_zero", ch, 0);
    chk("err_in_done", err, 0);
    ch_ready = 1'($urandom);
  endtask

  task automatic idle_gap();
    @(negedge clk);
    chk("done_pulse_1cyc", done, 0);
    chk("idle_valid", ch_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_err", err, 0);
  endtask

  task automatic illegal_job(input int n, input logic [31:0] t);
    start = 1'b1; len = LEN_W'(n); terms = t; ops = 7'($urandom);
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    chk("err_valid", ch_valid, 0);
    chk("err_done", done, 0);
    @(negedge clk);
    chk("err_1cyc", err, 0);
    chk("err_valid2", ch_valid, 0);
  endtask

  initial begin
    int n;
    logic [31:0] t;
    clr = 1'b1; start = 1'b0; ch_ready = 1'b1; len = '0; terms = '0; ops = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ch", ch, 0);
    chk("rst_valid", ch_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    clr = 1'b0;
    @(negedge clk);

    // Case 1: terms {0,7,2}, ops=01, ready high; also the two-digit prefix as its own job
    run_job(3, 32'h072, 7'b0000001, 0);
    idle_gap();
    run_job(2, 32'h072, 7'b0000001, 0);
    idle_gap();

    // Case 2: backpressure on '*'
    run_job(3, 32'h072, 7'b0000001, 2);
    idle_gap();

    // Case 3: illegal jobs, and an unused bad term that must be ignored
    illegal_job(0, 32'h0);
    illegal_job(9, 32'h0);
    illegal_job(2, 32'h0A3);
    run_job(2, 32'hF53, 7'b0000000, 0);
    idle_gap();

    // Case 4: boundaries and back-to-back
    run_job(1, 32'h9, 7'b0, 0);
    idle_gap();
    run_job(MAX_TERMS, 32'h9876_5432, 7'b1010011, 1);
    run_job(2, 32'h18, 7'b0000001, 0);
    idle_gap();

    // Case 5: reset while emitting an operator
    start = 1'b1; len = LEN_W'(3); terms = 32'h072; ops = 7'b0000001; ch_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("pre_rst_digit", ch, CH_ZERO + 8'd2);
    @(negedge clk);
    chk("pre_rst_op", ch, CH_MUL);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("mid_rst_valid", ch_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ch", ch, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    chk("post_rst_valid", ch_valid, 0);
    run_job(3, 32'h345, 7'b0000010, 0);
    idle_gap();

    // Case 6: random legal jobs with random backpressure
    for (int j = 0; j < 30; j++) begin
      n = $urandom_range(1, MAX_TERMS);
      t = '0;
      for (int i = 0; i < MAX_TERMS; i++) t[4*i +: 4] = 4'($urandom_range(0, 9));
      run_job(n, t, 7'($urandom), 1);
      if ($urandom_range(0, 1) == 0) idle_gap();
    end
    idle_gap();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
